run_ctrl: RTL
=============

Name: run_ctrl

Overview:
- Run/step controller directly upstream of the multicycle phase sequencer (3-phase FETCH/PREP/EXEC counter, advancing on negedge clk while its enable is high).
- Generates that enable as a registered `sm_en`, so `sm_en` is stable at every negedge.
- Supports free-run, single-instruction step, stop-at-instruction-boundary and halt-on-HLT.
- Keeps cycle and retired-instruction counters for the front panel / debug.

Parameters:
- CNT_W, 16, width of cyc_cnt and instr_cnt.
- S_FETCH, 2'b00, phase code for FETCH.
- S_PREP, 2'b01, phase code for PREP.
- S_EXEC, 2'b10, phase code for EXEC.

Ports:
- clk  in  1  system clock; all state in this block updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- sm  in  2  current phase from the sequencer.
- start  in  1  level or pulse; begin or resume free-run.
- stop  in  1  request stop at the next instruction boundary.
- step_req  in  1  execute exactly one instruction.
- halt_instr  in  1  decoder flag: the instruction in EXEC is HLT.
- sm_en  out  1  registered enable to the sequencer.
- busy  out  1  high in RUN or STEP.
- halted  out  1  high in HALTED.
- cyc_cnt  out  CNT_W  count of enabled phase advances.
- instr_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: state IDLE, sm_en 0, busy 0, halted 0, cyc_cnt 0, instr_cnt 0, stop_pend 0.
  - The sequencer itself is not reset. After reset, operation resumes from whatever phase `sm` holds.
- Timing: sm_en is written at posedge t and consumed by the sequencer at the following negedge.
- States: IDLE, RUN, STEP, HALTED.
- retire = (sm_en == 1 && sm == S_EXEC) at a posedge.
  - This means the coming negedge takes EXEC->FETCH.
  - A value of sm == 2'b11 is never treated as EXEC.
- IDLE:
  - sm_en <= 0.
  - start -> RUN, sm_en <= 1 on the same edge.
  - Else step_req -> STEP, sm_en <= 1.
  - start has priority over step_req.
  - start together with stop stays in IDLE.
- RUN:
  - sm_en <= 1.
  - stop sets stop_pend. step_req and start are ignored.
  - At retire:
    - instr_cnt += 1.
    - If halt_instr: -> HALTED.
    - Else if stop_pend or stop: -> IDLE, clear stop_pend.
    - sm_en is still written 1 on the retire edge, so the EXEC->FETCH transition completes. The next state writes 0 on the following posedge.
- STEP:
  - sm_en <= 1.
  - At retire: instr_cnt += 1; -> HALTED if halt_instr, else -> IDLE.
  - Net effect: exactly one instruction boundary is crossed and the sequencer rests in FETCH.
  - start, stop and step_req are ignored in STEP.
- HALTED:
  - sm_en <= 0, halted = 1.
  - start -> RUN and clears halted. step_req -> STEP.
  - Both are allowed, so the operator can resume past HLT.
- Outputs: busy = (state == RUN || state == STEP), registered with state.
- cyc_cnt: += 1 at every posedge where the current sm_en == 1. Wraps modulo 2^CNT_W with no saturation.
- instr_cnt: += 1 per retire. Wraps modulo 2^CNT_W.
- Step from mid-instruction (e.g. after reset with sm == S_PREP): STEP runs to the next retire only, i.e. a partial instruction, and still counts 1.
- Reset mid-operation: immediate. sm_en drops asynchronously, so the next negedge does not advance the sequencer.
- Inputs start, stop, step_req and halt_instr are synchronous to clk. No debouncing is done here.

Test Plan:
1. Reset, sm = FETCH, pulse step_req 1 cycle -> sm_en high for exactly 3 negedges; sm sequence FETCH, PREP, EXEC, FETCH; instr_cnt = 1; cyc_cnt = 3; busy 0 afterwards; sm rests at FETCH.
2. start, then free-run 4 instructions, pulse stop while sm = PREP -> run ends at the next retire; instr_cnt = 5, cyc_cnt = 15, sm = FETCH, state IDLE.
3. RUN with halt_instr high during the 2nd EXEC -> halted = 1, instr_cnt = 2, sm_en 0; then start -> RUN resumes and halted clears.
4. start and stop asserted together in IDLE -> sm_en stays 0; start with step_req -> RUN (free-run, not a single step).
5. CNT_W = 4, free-run 6 instructions -> cyc_cnt wraps 15->0 and reads 2 after 18 advances; instr_cnt = 6.
6. Deassert rst_n between a posedge with sm_en = 1 and the following negedge, during PREP -> sm_en 0 immediately; sequencer stays in PREP; counters 0; a subsequent step_req ends at FETCH with instr_cnt = 1, cyc_cnt = 2.

Source files
------------

// File: rtl/run_ctrl_if.sv
// run_ctrl_if: control/status bundle between the run controller,
// the front panel and the phase sequencer.
interface run_ctrl_if #(
    parameter int CNT_W = 16
) ();

    // Sequencer side
    logic [1:0]       sm;
    logic             halt_instr;
    logic             sm_en;

    // Front panel / debug side
    logic             start;
    logic             stop;
    logic             step_req;
    logic             busy;
    logic             halted;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] instr_cnt;

    // Environment: drives the phase and operator requests
    modport master (
        output sm,
        output halt_instr,
        output start,
        output stop,
        output step_req,
        input  sm_en,
        input  busy,
        input  halted,
        input  cyc_cnt,
        input  instr_cnt
    );

    // Controller: consumes requests, drives enable and status
    modport slave (
        input  sm,
        input  halt_instr,
        input  start,
        input  stop,
        input  step_req,
        output sm_en,
        output busy,
        output halted,
        output cyc_cnt,
        output instr_cnt
    );

endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: run/step/stop/halt controller producing the registered
// enable for the 3-phase FETCH/PREP/EXEC sequencer, plus debug counters.
module run_ctrl #(
    parameter int         CNT_W   = 16,
    parameter logic [1:0] S_FETCH = 2'b00,
    parameter logic [1:0] S_PREP  = 2'b01,
    parameter logic [1:0] S_EXEC  = 2'b10
) (
    input  logic      clk,
    input  logic      rst_n,
    run_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic             sm_en_q, sm_en_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             stop_pend_q, stop_pend_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    logic             sm_legal;
    logic             retire;

    // Only the three defined phase codes are meaningful; 2'b11 never retires.
    assign sm_legal = (bus.sm == S_FETCH) || (bus.sm == S_PREP) ||
                      (bus.sm == S_EXEC);

    // Enable is high while the sequencer sits in EXEC: the coming
    // negedge completes the instruction (EXEC -> FETCH).
    assign retire = sm_en_q && sm_legal && (bus.sm == S_EXEC);

    // Next-state, enable and counter logic
    always_comb begin
        state_d     = state_q;
        sm_en_d     = 1'b0;
        stop_pend_d = stop_pend_q;
        cyc_cnt_d   = cyc_cnt_q + {{(CNT_W-1){1'b0}}, sm_en_q};
        instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, retire};

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (!bus.stop) begin
                        state_d = RUN;
                        sm_en_d = 1'b1;
                    end
                end else if (bus.step_req) begin
                    state_d = STEP;
                    sm_en_d = 1'b1;
                end
            end

            RUN: begin
                // Held high on the retire edge so EXEC -> FETCH completes.
                sm_en_d = 1'b1;
                if (bus.stop) begin
                    stop_pend_d = 1'b1;
                end
                if (retire) begin
                    if (bus.halt_instr) begin
                        state_d     = HALTED;
                        stop_pend_d = 1'b0;
                    end else if (stop_pend_q || bus.stop) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                    end
                end
            end

            STEP: begin
                sm_en_d = 1'b1;
                if (retire) begin
                    state_d = bus.halt_instr ? HALTED : IDLE;
                end
            end

            HALTED: begin
                // Operator may resume past HLT with either request.
                if (bus.start) begin
                    state_d = RUN;
                    sm_en_d = 1'b1;
                end else if (bus.step_req) begin
                    state_d = STEP;
                    sm_en_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d   = (state_d == RUN) || (state_d == STEP);
        halted_d = (state_d == HALTED);
    end

    // State, enable, status and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sm_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            stop_pend_q <= 1'b0;
            cyc_cnt_q   <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sm_en_q     <= sm_en_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            stop_pend_q <= stop_pend_d;
            cyc_cnt_q   <= cyc_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign bus.sm_en     = sm_en_q;
    assign bus.busy      = busy_q;
    assign bus.halted    = halted_q;
    assign bus.cyc_cnt   = cyc_cnt_q;
    assign bus.instr_cnt = instr_cnt_q;

endmodule
